// File: rtl/pa_stack_ctrl.sv
// Play-area stack controller: tracks the current play area, saves/restores it
// on a small LIFO and forms register-file addresses from it.
module pa_stack_ctrl #(
  parameter int DEPTH = 4,
  parameter int SPW   = $clog2(DEPTH + 1)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           op_valid,
  input  logic [1:0]     op,
  input  logic [1:0]     op_pa,
  input  logic           clr_err,
  input  logic [1:0]     rd_lo_a,
  input  logic [1:0]     rd_lo_b,
  input  logic [1:0]     wr_lo,
  output logic [1:0]     cur_pa,
  output logic [3:0]     rd_addr_a,
  output logic [3:0]     rd_addr_b,
  output logic [3:0]     wr_addr,
  output logic [SPW-1:0] depth,
  output logic           full,
  output logic           empty,
  output logic           ovf_err,
  output logic           unf_err
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_SET  = 2'b01;
  localparam logic [1:0] OP_PUSH = 2'b10;
  localparam logic [1:0] OP_POP  = 2'b11;

  logic [1:0]     stack_q [DEPTH];
  logic [1:0]     cur_pa_q, cur_pa_d;
  logic [SPW-1:0] sp_q, sp_d;
  logic           ovf_q, ovf_d;
  logic           unf_q, unf_d;
  logic           push_we;
  logic           ovf_set, unf_set;
  logic [IW-1:0]  wr_idx, rd_idx;

  assign full   = (sp_q == SPW'(DEPTH));
  assign empty  = (sp_q == '0);
  assign wr_idx = IW'(sp_q);
  assign rd_idx = IW'(sp_q - SPW'(1));

  always_comb begin
    cur_pa_d = cur_pa_q;
    sp_d     = sp_q;
    push_we  = 1'b0;
    ovf_set  = 1'b0;
    unf_set  = 1'b0;
    if (op_valid) begin
      case (op)
        OP_NOP: ;
        OP_SET: cur_pa_d = op_pa;
        OP_PUSH: begin
          if (!full) begin
            push_we  = 1'b1;
            sp_d     = sp_q + SPW'(1);
            cur_pa_d = op_pa;
          end else begin
            ovf_set = 1'b1;
          end
        end
        OP_POP: begin
          if (!empty) begin
            cur_pa_d = stack_q[rd_idx];
            sp_d     = sp_q - SPW'(1);
          end else begin
            unf_set = 1'b1;
          end
        end
        default: ;
      endcase
    end
    // An error raised by this cycle's op beats a concurrent clear.
    ovf_d = ovf_set | (ovf_q & ~clr_err);
    unf_d = unf_set | (unf_q & ~clr_err);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_pa_q <= 2'b00;
      sp_q     <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      cur_pa_q <= cur_pa_d;
      sp_q     <= sp_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Saved entries need no reset; anything at or above sp is never read.
  always_ff @(posedge clk) begin
    if (!reset && push_we) stack_q[wr_idx] <= cur_pa_q;
  end

  assign cur_pa    = cur_pa_q;
  assign depth     = sp_q;
  assign ovf_err   = ovf_q;
  assign unf_err   = unf_q;
  assign rd_addr_a = {cur_pa_q, rd_lo_a};
  assign rd_addr_b = {cur_pa_q, rd_lo_b};
  assign wr_addr   = {cur_pa_q, wr_lo};

endmodule

// File: tb/tb_pa_stack_ctrl.sv
// Bench for pa_stack_ctrl: directed vector table, hand sequences, then random
// ops checked against a queue-based reference model.
module tb_pa_stack_ctrl;

  localparam int DEPTH = 4;
  localparam int SPW   = 3;

  logic           clk = 1'b0;
  logic           reset, op_valid, clr_err;
  logic [1:0]     op, op_pa, rd_lo_a, rd_lo_b, wr_lo;
  logic [1:0]     cur_pa;
  logic [3:0]     rd_addr_a, rd_addr_b, wr_addr;
  logic [SPW-1:0] depth;
  logic           full, empty, ovf_err, unf_err;

  int checks = 0;
  int errors = 0;

  pa_stack_ctrl #(.DEPTH(DEPTH), .SPW(SPW)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op(op), .op_pa(op_pa),
    .clr_err(clr_err), .rd_lo_a(rd_lo_a), .rd_lo_b(rd_lo_b), .wr_lo(wr_lo),
    .cur_pa(cur_pa), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .wr_addr(wr_addr), .depth(depth), .full(full), .empty(empty),
    .ovf_err(ovf_err), .unf_err(unf_err)
  );

  always #5 clk = ~clk;

  // Reference model: the saved play areas live in a plain queue.
  int   m_cur;
  int   m_stk[$];
  bit   m_ovf, m_unf;
  bit   m_valid = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic void model_step(input bit r, input bit v, input int o,
                                     input int pa, input bit c);
    bit os = 0, us = 0;
    if (r) begin
      m_cur = 0; m_stk.delete(); m_ovf = 0; m_unf = 0;
      return;
    end
    if (v) begin
      if (o == 1) m_cur = pa;
      else if (o == 2) begin
        if (m_stk.size() < DEPTH) begin m_stk.push_back(m_cur); m_cur = pa; end
        else os = 1;
      end else if (o == 3) begin
        if (m_stk.size() > 0) m_cur = m_stk.pop_back();
        else us = 1;
      end
    end
    m_ovf = os | (m_ovf & ~c);
    m_unf = us | (m_unf & ~c);
  endfunction

  task automatic check_model(input string tag);
    chk({tag, ".no_x"}, int'($isunknown({cur_pa, depth, full, empty, ovf_err, unf_err,
                                           rd_addr_a, rd_addr_b, wr_addr})), 0);
    chk({tag, ".cur_pa"}, cur_pa, m_cur);
    chk({tag, ".depth"}, depth, m_stk.size());
    chk({tag, ".full"}, full, int'(m_stk.size() == DEPTH));
    chk({tag, ".empty"}, empty, int'(m_stk.size() == 0));
    chk({tag, ".ovf"}, ovf_err, m_ovf);
    chk({tag, ".unf"}, unf_err, m_unf);
    chk({tag, ".rd_a"}, rd_addr_a, m_cur * 4 + rd_lo_a);
    chk({tag, ".rd_b"}, rd_addr_b, m_cur * 4 + rd_lo_b);
    chk({tag, ".wr"}, wr_addr, m_cur * 4 + wr_lo);
  endtask

  // Drive at the falling edge; addresses before the edge must use the old play area.
  task automatic cycle(input bit r, input bit v, input logic [1:0] o, input logic [1:0] pa,
                       input bit c, input logic [1:0] la, input logic [1:0] lb,
                       input logic [1:0] lw, input string tag);
    reset = r; op_valid = v; op = o; op_pa = pa; clr_err = c;
    rd_lo_a = la; rd_lo_b = lb; wr_lo = lw;
    #1;
    if (m_valid) begin
      chk({tag, ".pre_rd_a"}, rd_addr_a, m_cur * 4 + la);
      chk({tag, ".pre_wr"}, wr_addr, m_cur * 4 + lw);
    end
    @(posedge clk);
    model_step(r, v, int'(o), int'(pa), c);
    if (r) m_valid = 1'b1;
    @(negedge clk);
    check_model(tag);
  endtask

  typedef struct {
    bit       r, v;
    bit [1:0] o, pa;
    bit       c;
    bit [1:0] la, lb, lw;
    int       e_cur, e_depth, e_ovf, e_unf;
  } vec_t;

  vec_t vt[$];

  function automatic void add(bit r, bit v, bit [1:0] o, bit [1:0] pa, bit c,
                              bit [1:0] la, bit [1:0] lb, bit [1:0] lw,
                              int ec, int ed, int eo, int eu);
    vec_t x;
    x.r = r; x.v = v; x.o = o; x.pa = pa; x.c = c;
    x.la = la; x.lb = lb; x.lw = lw;
    x.e_cur = ec; x.e_depth = ed; x.e_ovf = eo; x.e_unf = eu;
    vt.push_back(x);
  endfunction

  initial begin
    reset = 1'b1; op_valid = 1'b0; op = 2'b00; op_pa = 2'b00; clr_err = 1'b0;
    rd_lo_a = 2'b00; rd_lo_b = 2'b00; wr_lo = 2'b00;

    //   r v op  pa  c  la lb lw   cur dep ovf unf
    add(1,1,2'd2,2'd2,1, 2,0,3,    0,  0,  0,  0);  // reset discards same-cycle push
    add(0,1,2'd1,2'd3,0, 2,1,3,    3,  0,  0,  0);  // SET 3 -> rd_addr_b = 4'hD
    add(0,1,2'd1,2'd0,0, 0,0,0,    0,  0,  0,  0);
    add(0,1,2'd2,2'd1,0, 1,2,3,    1,  1,  0,  0);
    add(0,1,2'd2,2'd2,0, 1,2,3,    2,  2,  0,  0);
    add(0,1,2'd2,2'd3,0, 1,2,3,    3,  3,  0,  0);
    add(0,1,2'd2,2'd0,0, 1,2,3,    0,  4,  0,  0);
    add(0,1,2'd3,2'd1,0, 0,1,2,    3,  3,  0,  0);
    add(0,1,2'd3,2'd2,0, 0,1,2,    2,  2,  0,  0);
    add(0,1,2'd3,2'd3,0, 0,1,2,    1,  1,  0,  0);
    add(0,1,2'd3,2'd0,0, 0,1,2,    0,  0,  0,  0);
    add(0,1,2'd3,2'd0,0, 3,3,3,    0,  0,  0,  1);  // pop when empty
    add(0,0,2'd0,2'd0,1, 3,3,3,    0,  0,  0,  0);  // clear alone
    add(0,1,2'd3,2'd0,1, 3,3,3,    0,  0,  0,  1);  // same-cycle error beats clear
    add(0,0,2'd0,2'd0,1, 3,3,3,    0,  0,  0,  0);
    add(0,1,2'd2,2'd1,0, 2,2,2,    1,  1,  0,  0);
    add(0,1,2'd2,2'd2,0, 2,2,2,    2,  2,  0,  0);
    add(0,1,2'd2,2'd3,0, 2,2,2,    3,  3,  0,  0);
    add(0,1,2'd2,2'd0,0, 2,2,2,    0,  4,  0,  0);
    add(0,1,2'd2,2'd2,0, 2,2,2,    0,  4,  1,  0);  // fifth push overflows
    add(0,1,2'd2,2'd1,1, 2,2,2,    0,  4,  1,  0);
    add(0,0,2'd0,2'd0,1, 2,2,2,    0,  4,  0,  0);
    add(1,0,2'd0,2'd0,0, 0,0,0,    0,  0,  0,  0);
    add(0,1,2'd2,2'd2,0, 0,0,0,    2,  1,  0,  0);
    add(1,1,2'd3,2'd0,0, 0,0,0,    0,  0,  0,  0);  // mid-stack reset, pop discarded
    add(0,1,2'd3,2'd0,0, 0,0,0,    0,  0,  0,  1);
    add(0,1,2'd2,2'd2,0, 1,1,1,    2,  1,  0,  1);
    add(0,1,2'd3,2'd1,0, 1,1,1,    0,  0,  0,  1);  // push/pop restores old cur_pa

    @(negedge clk);
    for (int i = 0; i < vt.size(); i++) begin
      string tg;
      tg = $sformatf("vec%0d", i);
      cycle(vt[i].r, vt[i].v, vt[i].o, vt[i].pa, vt[i].c,
            vt[i].la, vt[i].lb, vt[i].lw, tg);
      chk({tg, ".tbl_cur"}, cur_pa, vt[i].e_cur);
      chk({tg, ".tbl_depth"}, depth, vt[i].e_depth);
      chk({tg, ".tbl_ovf"}, ovf_err, vt[i].e_ovf);
      chk({tg, ".tbl_unf"}, unf_err, vt[i].e_unf);
      chk({tg, ".tbl_rd_a"}, rd_addr_a, vt[i].e_cur * 4 + vt[i].la);
      chk({tg, ".tbl_rd_b"}, rd_addr_b, vt[i].e_cur * 4 + vt[i].lb);
      chk({tg, ".tbl_wr"}, wr_addr, vt[i].e_cur * 4 + vt[i].lw);
    end

    // Invalid ops are ignored even with PUSH on the bus.
    cycle(0, 1, 2'd2, 2'd3, 0, 0, 0, 0, "idle_setup");
    for (int i = 0; i < 10; i++) begin
      cycle(0, 0, 2'd2, 2'(i), 0, 1, 2, 3, "idle_push");
      chk("idle.cur", cur_pa, 3);
      chk("idle.depth", depth, 1);
    end

    // Back-to-back push/pop pairs restore the pre-push play area.
    cycle(0, 1, 2'd1, 2'd1, 1, 0, 0, 0, "b2b_set");
    for (int i = 0; i < 4; i++) begin
      cycle(0, 1, 2'd2, 2'(i), 0, 0, 0, 0, "b2b_push");
      cycle(0, 1, 2'd3, 2'd0, 0, 0, 0, 0, "b2b_pop");
      chk("b2b.restore", cur_pa, 1);
    end

    for (int i = 0; i < 600; i++) begin
      bit r, v, c;
      r = ($urandom_range(0, 39) == 0);
      v = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 7) == 0);
      cycle(r, v, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), c,
            2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            2'($urandom_range(0, 3)), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
